// File: rtl/cam_pkg.sv
// cam_pkg: shared frame geometry, capture FSM states and RGB444 packing
package cam_pkg;
    localparam int H_RES    = 176;
    localparam int V_RES    = 144;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int FIELD_W  = 4;
    localparam int R_LSB    = 8;
    localparam int G_LSB    = 4;
    localparam int B_LSB    = 0;
    typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE_LO} state_e;
    function automatic logic [11:0] pack_rgb444(input logic [7:0] hi, input logic [7:0] lo);
        logic [11:0] px;
        px                      = '0;
        px[R_LSB +: FIELD_W]    = hi[3:0];
        px[G_LSB +: FIELD_W]    = lo[7:4];
        px[B_LSB +: FIELD_W]    = lo[3:0];
        return px;
    endfunction
endpackage

// File: rtl/cam_capture_qcif_sync.sv
// cam_sync_edge: 2-flop synchroniser with registered rise/fall detect
// clk_i/rst_i: system clock and sync active-high reset
// d_i: asynchronous input; lvl_o: synchronised level aligned with rise_o/fall_o
module cam_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sync_q;
    logic       rise_q;
    logic       fall_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
            rise_q <= sync_q[1] & ~sync_q[2];
            fall_q <= ~sync_q[1] & sync_q[2];
        end
    end
    assign lvl_o  = sync_q[2];
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/cam_capture_qcif.sv
// cam_capture_qcif: packs OV7670 RGB444 byte pairs into raster-addressed framebuffer writes
// Clock/Reset: system clock, sync active-high reset
// CamPclk/CamHref/CamVsync/CamData: asynchronous camera bus, sampled as data
// DataRamIn/AddrRamIn/WriteEnable: framebuffer write port; FrameDone: end-of-frame pulse
module cam_capture_qcif #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 15,
    parameter int H_RES  = cam_pkg::H_RES,
    parameter int V_RES  = cam_pkg::V_RES
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CamPclk,
    input  logic              CamHref,
    input  logic              CamVsync,
    input  logic [7:0]        CamData,
    output logic [DATA_W-1:0] DataRamIn,
    output logic [ADDR_W-1:0] AddrRamIn,
    output logic              WriteEnable,
    output logic              FrameDone
);
    import cam_pkg::*;
    logic pclk_lvl, pclk_rise, pclk_fall;
    logic href_lvl, href_rise, href_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic unused_ok;
    cam_sync_edge u_pclk (.clk_i(Clock), .rst_i(Reset), .d_i(CamPclk),  .lvl_o(pclk_lvl), .rise_o(pclk_rise), .fall_o(pclk_fall));
    cam_sync_edge u_href (.clk_i(Clock), .rst_i(Reset), .d_i(CamHref),  .lvl_o(href_lvl), .rise_o(href_rise), .fall_o(href_fall));
    cam_sync_edge u_vs   (.clk_i(Clock), .rst_i(Reset), .d_i(CamVsync), .lvl_o(vs_lvl),   .rise_o(vs_rise),   .fall_o(vs_fall));
    assign unused_ok = &{1'b0, pclk_lvl, pclk_fall, href_rise, vs_lvl};
    // Three stages so the byte lines up with the registered pclk rise pulse
    logic [2:0][7:0]    dat_q;
    state_e             st_q, st_d;
    logic [8:0]         x_q, x_d;
    logic [7:0]         y_q, y_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [7:0]         hi_q, hi_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic               fd_q, fd_d;
    always_comb begin
        st_d   = st_q;
        x_d    = x_q;
        y_d    = y_q;
        base_d = base_q;
        hi_d   = hi_q;
        data_d = data_q;
        addr_d = addr_q;
        we_d   = 1'b0;
        fd_d   = 1'b0;
        if (vs_rise && st_q != WAIT_FRAME) begin
            fd_d   = y_q != 8'd0;
            st_d   = WAIT_FRAME;
            x_d    = '0;
            y_d    = '0;
            base_d = '0;
        end else if (st_q == WAIT_FRAME) begin
            st_d = vs_fall ? WAIT_LINE : WAIT_FRAME;
        end else begin
            if (pclk_rise && href_lvl) begin
                st_d = st_q == WAIT_LINE ? BYTE_LO : WAIT_LINE;
                hi_d = st_q == WAIT_LINE ? dat_q[2] : hi_q;
                if (st_q == BYTE_LO) begin
                    we_d   = x_q < 9'(H_RES) && y_q < 8'(V_RES);
                    data_d = we_d ? DATA_W'(pack_rgb444(hi_q, dat_q[2])) : data_q;
                    addr_d = we_d ? base_q + ADDR_W'(x_q) : addr_q;
                    x_d    = x_q < 9'(H_RES) ? x_q + 9'd1 : x_q;
                end
            end
            // x_d already includes a pixel finishing this cycle, so that pixel counts toward the line
            if (href_fall) begin
                st_d   = WAIT_LINE;
                y_d    = x_d != 9'd0 && y_q < 8'(V_RES) ? y_q + 8'd1 : y_q;
                base_d = x_d != 9'd0 && y_q < 8'(V_RES) ? base_q + ADDR_W'(H_RES) : base_q;
                x_d    = '0;
            end
        end
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            dat_q  <= '0;
            st_q   <= WAIT_FRAME;
            x_q    <= '0;
            y_q    <= '0;
            base_q <= '0;
            hi_q   <= '0;
            data_q <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            dat_q  <= {dat_q[1:0], CamData};
            st_q   <= st_d;
            x_q    <= x_d;
            y_q    <= y_d;
            base_q <= base_d;
            hi_q   <= hi_d;
            data_q <= data_d;
            addr_q <= addr_d;
            we_q   <= we_d;
            fd_q   <= fd_d;
        end
    end
    assign DataRamIn   = data_q;
    assign AddrRamIn   = addr_q;
    assign WriteEnable = we_q;
    assign FrameDone   = fd_q;
endmodule
